// File: rtl/draw_pkg.sv
// Shared constants for the sprite draw path: arbiter state encodings,
// screen coordinate widths, colour codes and fixed requester slots.
package draw_pkg;

    localparam int SCREEN_XW = 8;
    localparam int SCREEN_YW = 7;
    localparam int CW        = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [CW-1:0] COL_ERASE = 3'b000;
    localparam logic [CW-1:0] COL_LASER = 3'b110;

    localparam int REQ_ROCKET = 0;
    localparam int REQ_LASER  = 1;

    // clog2 that never returns zero, so single-entry counters still get one bit
    function automatic int safeClog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping
// modulo N (works for non-power-of-two N).
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_anyReq
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Scan ptr+1 .. ptr+N so the last winner has the lowest priority next time
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_anyReq = |i_req;

endmodule

// File: rtl/draw_arbiter.sv
// Shares the single sprite draw engine among N requesters (rocket, laser,
// asteroids) with round-robin grants and a watchdog on the engine's done.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int N       = 4,
    parameter int XW      = draw_pkg::SCREEN_XW,
    parameter int YW      = draw_pkg::SCREEN_YW,
    parameter int CW      = draw_pkg::CW,
    parameter int TIMEOUT = 4096
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    i_req,
    input  logic [N*XW-1:0] i_req_x,
    input  logic [N*YW-1:0] i_req_y,
    input  logic [N*CW-1:0] i_req_color,
    output logic [N-1:0]    o_grant,
    output logic [N-1:0]    o_done,
    output logic            o_timeout_err,
    output logic            o_eng_start,
    output logic [XW-1:0]   o_eng_x,
    output logic [YW-1:0]   o_eng_y,
    output logic [CW-1:0]   o_eng_color,
    input  logic            i_eng_done,
    output logic            o_busy
);

    localparam int PW  = safeClog2(N);
    localparam int WDW = safeClog2(TIMEOUT);

    localparam logic [PW-1:0]  PTR_INIT = PW'(N - 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [WDW-1:0] r_wd;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_owner;
    logic [PW-1:0] r_ownerIdx;
    logic [N-1:0]  r_done;
    logic          r_timeoutErr;
    logic          r_engStart;
    logic [XW-1:0] r_engX;
    logic [YW-1:0] r_engY;
    logic [CW-1:0] r_engColor;

    logic [N-1:0]  w_pickGrant;
    logic          w_anyReq;
    logic [PW-1:0] w_pickIdx;
    logic [XW-1:0] w_pickX;
    logic [YW-1:0] w_pickY;
    logic [CW-1:0] w_pickColor;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_grant  (w_pickGrant),
        .o_anyReq (w_anyReq)
    );

    // Winner index selects the coordinate slices and becomes the next pointer
    always_comb begin
        w_pickIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pickGrant[i]) begin
                w_pickIdx = PW'(i);
            end
        end
    end

    assign w_pickX     = i_req_x[int'(w_pickIdx)*XW +: XW];
    assign w_pickY     = i_req_y[int'(w_pickIdx)*YW +: YW];
    assign w_pickColor = i_req_color[int'(w_pickIdx)*CW +: CW];

    // Engine done wins over a coincident watchdog expiry; either way the owner gets its done
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= PTR_INIT;
            r_wd         <= '0;
            r_grant      <= '0;
            r_owner      <= '0;
            r_ownerIdx   <= '0;
            r_done       <= '0;
            r_timeoutErr <= 1'b0;
            r_engStart   <= 1'b0;
            r_engX       <= '0;
            r_engY       <= '0;
            r_engColor   <= CW'(COL_ERASE);
        end else begin
            r_engStart   <= 1'b0;
            r_done       <= '0;
            r_timeoutErr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_state    <= ST_ISSUE;
                        r_grant    <= w_pickGrant;
                        r_owner    <= w_pickGrant;
                        r_ownerIdx <= w_pickIdx;
                        r_engX     <= w_pickX;
                        r_engY     <= w_pickY;
                        r_engColor <= w_pickColor;
                        r_engStart <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_wd    <= '0;
                end
                ST_WAIT: begin
                    if (i_eng_done || (r_wd == WD_LAST)) begin
                        r_state      <= ST_RELEASE;
                        r_grant      <= '0;
                        r_done       <= r_owner;
                        r_timeoutErr <= !i_eng_done;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_ptr   <= r_ownerIdx;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_done        = r_done;
    assign o_timeout_err = r_timeoutErr;
    assign o_eng_start   = r_engStart;
    assign o_eng_x       = r_engX;
    assign o_eng_y       = r_engY;
    assign o_eng_color   = r_engColor;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: a transaction-level reference model
// predicts starts and dones, a negedge monitor pops and compares them.
module tb_draw_arbiter;
    import draw_pkg::*;

    localparam int N       = 4;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int CW      = 3;
    localparam int TIMEOUT = 24;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    reqR;
    logic [N*XW-1:0] reqX;
    logic [N*YW-1:0] reqY;
    logic [N*CW-1:0] reqCol;
    logic            engDoneR;
    logic [N-1:0]    o_grant;
    logic [N-1:0]    o_done;
    logic            o_timeout_err;
    logic            o_eng_start;
    logic [XW-1:0]   o_eng_x;
    logic [YW-1:0]   o_eng_y;
    logic [CW-1:0]   o_eng_color;
    logic            o_busy;

    always #5 clock = ~clock;

    draw_arbiter #(
        .N       (N),
        .XW      (XW),
        .YW      (YW),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_req         (reqR),
        .i_req_x       (reqX),
        .i_req_y       (reqY),
        .i_req_color   (reqCol),
        .o_grant       (o_grant),
        .o_done        (o_done),
        .o_timeout_err (o_timeout_err),
        .o_eng_start   (o_eng_start),
        .o_eng_x       (o_eng_x),
        .o_eng_y       (o_eng_y),
        .o_eng_color   (o_eng_color),
        .i_eng_done    (engDoneR),
        .o_busy        (o_busy)
    );

    typedef struct {
        int            cyc;
        int            idx;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] col;
    } issue_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] oh;
        logic         to;
    } done_t;

    issue_t       issueQ[$];
    done_t        doneQ[$];
    logic         expBusy[int];
    logic [N-1:0] expGrant[int];

    int testsRun = 0;
    int failures = 0;
    int cycle    = 0;
    bit monOn    = 0;

    logic [XW-1:0] xs[N];
    logic [YW-1:0] ys[N];
    logic [CW-1:0] cols[N];
    logic [N-1:0]  holdMask  = '0;
    logic [N-1:0]  raiseNow  = '0;
    bit            randomRaise = 0;
    bit            spurious    = 0;
    bit            fixedVals   = 0;
    bit            rstNow      = 0;
    int            fixedDelay  = -1;

    bit mActive   = 0;
    int mStart    = 0;
    int mDoneAt   = 0;
    int mIdleFrom = 0;
    int mPtr      = N - 1;
    int mWin      = 0;

    always @(posedge clock) cycle <= cycle + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqX[i*XW +: XW]   = xs[i];
            reqY[i*YW +: YW]   = ys[i];
            reqCol[i*CW +: CW] = cols[i];
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    // Round-robin reference: first requester after the last one served
    function automatic int pickModel(input logic [N-1:0] r, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Engine response delay in cycles after start; 0 means the engine hangs
    function automatic int chooseDelay();
        if (fixedDelay >= 0) return fixedDelay;
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return TIMEOUT;
            2:       return TIMEOUT - 1;
            3:       return 1;
            default: return int'($urandom_range(2, 10));
        endcase
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic applyStimulus();
        int           c;
        int           w;
        bit           inWindow;
        logic [N-1:0] dropped;
        @(posedge clock);
        #1;
        c = cycle;
        dropped = '0;
        for (int i = 0; i < N; i++) begin
            if (o_done[i]) begin
                reqR[i]    = 1'b0;
                dropped[i] = 1'b1;
            end
        end
        reqR     = reqR | raiseNow;
        raiseNow = '0;
        for (int i = 0; i < N; i++) begin
            if (!reqR[i] && !dropped[i] && (holdMask[i] || (randomRaise && $urandom_range(0, 3) == 0)))
                reqR[i] = 1'b1;
        end
        if (!fixedVals) begin
            for (int i = 0; i < N; i++) begin
                xs[i]   = XW'($urandom);
                ys[i]   = YW'($urandom);
                cols[i] = CW'($urandom);
            end
        end
        inWindow = mActive && (c > mStart) && (c <= mStart + TIMEOUT);
        engDoneR = 1'b0;
        if (!rstNow) begin
            if (mActive && mDoneAt != 0 && c == mStart + mDoneAt)
                engDoneR = 1'b1;
            else if (!inWindow && spurious && $urandom_range(0, 7) == 0)
                engDoneR = 1'b1;
        end
        expBusy[c]  = mActive || (c < mIdleFrom);
        expGrant[c] = mActive ? onehot(mWin) : '0;
        if (rstNow) begin
            reset = 1'b1;
            while (issueQ.size() > 0 && issueQ[$].cyc > c) void'(issueQ.pop_back());
            while (doneQ.size() > 0 && doneQ[$].cyc > c) void'(doneQ.pop_back());
            mActive   = 0;
            mIdleFrom = c + 1;
            mPtr      = N - 1;
        end else begin
            reset = 1'b0;
            if (inWindow) begin
                if (engDoneR || c == mStart + TIMEOUT) begin
                    doneQ.push_back('{cyc: c + 1, oh: onehot(mWin), to: !engDoneR});
                    mActive   = 0;
                    mIdleFrom = c + 2;
                    mPtr      = mWin;
                end
            end else if (!mActive && c >= mIdleFrom && reqR != '0) begin
                w = pickModel(reqR, mPtr);
                issueQ.push_back('{cyc: c + 1, idx: w, x: xs[w], y: ys[w], col: cols[w]});
                mActive = 1;
                mStart  = c + 1;
                mDoneAt = chooseDelay();
                mWin    = w;
            end
        end
    endtask

    task automatic checkOutput();
        issue_t it;
        done_t  dn;
        int     c;
        c = cycle;
        if (expBusy.exists(c)) begin
            checkVal("busy", 32'(o_busy), 32'(expBusy[c]));
            checkVal("grant", 32'(o_grant), 32'(expGrant[c]));
        end
        if (issueQ.size() > 0 && issueQ[0].cyc == c) begin
            it = issueQ.pop_front();
            checkVal("eng_start", 32'(o_eng_start), 32'd1);
            checkVal("start grant", 32'(o_grant), 32'(onehot(it.idx)));
            checkVal("eng_x", 32'(o_eng_x), 32'(it.x));
            checkVal("eng_y", 32'(o_eng_y), 32'(it.y));
            checkVal("eng_color", 32'(o_eng_color), 32'(it.col));
        end else begin
            checkVal("eng_start quiet", 32'(o_eng_start), 32'd0);
        end
        if (doneQ.size() > 0 && doneQ[0].cyc == c) begin
            dn = doneQ.pop_front();
            checkVal("done", 32'(o_done), 32'(dn.oh));
            checkVal("timeout_err", 32'(o_timeout_err), 32'(dn.to));
        end else begin
            checkVal("done quiet", 32'(o_done), 32'd0);
            checkVal("timeout_err quiet", 32'(o_timeout_err), 32'd0);
        end
    endtask

    always @(negedge clock) begin
        if (monOn) checkOutput();
    end

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic resetDut();
        rstNow = 1;
        applyStimulus();
        rstNow = 0;
    endtask

    initial begin
        reqR     = '0;
        engDoneR = 1'b0;
        for (int i = 0; i < N; i++) begin
            xs[i]   = '0;
            ys[i]   = '0;
            cols[i] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkVal("reset grant", 32'(o_grant), 32'd0);
        checkVal("reset done", 32'(o_done), 32'd0);
        checkVal("reset timeout_err", 32'(o_timeout_err), 32'd0);
        checkVal("reset eng_start", 32'(o_eng_start), 32'd0);
        checkVal("reset eng_x", 32'(o_eng_x), 32'd0);
        checkVal("reset eng_y", 32'(o_eng_y), 32'd0);
        checkVal("reset eng_color", 32'(o_eng_color), 32'(COL_ERASE));
        checkVal("reset busy", 32'(o_busy), 32'd0);
        monOn = 1;

        // Single rocket request with fixed origin and laser colour
        fixedVals             = 1;
        xs[REQ_ROCKET]        = 8'd8;
        ys[REQ_ROCKET]        = 7'd99;
        cols[REQ_ROCKET]      = COL_LASER;
        fixedDelay            = 20;
        raiseNow[REQ_ROCKET]  = 1'b1;
        runCycles(30);
        fixedVals = 0;

        // All four at once from reset: served 0,1,2,3
        resetDut();
        fixedDelay = 3;
        raiseNow   = 4'b1111;
        runCycles(40);

        // Two requesters re-raising continuously must alternate
        fixedDelay = 2;
        holdMask   = 4'b0011;
        runCycles(50);
        holdMask   = '0;
        runCycles(20);

        // Hung engine, then a normal request afterwards
        fixedDelay = 0;
        raiseNow   = 4'b0100;
        runCycles(TIMEOUT + 8);
        fixedDelay = 5;
        raiseNow   = 4'b0100;
        runCycles(15);

        // Engine done on the very last WAIT cycle
        fixedDelay = TIMEOUT;
        raiseNow   = 4'b0010;
        runCycles(TIMEOUT + 8);

        // Reset in the middle of a laser draw, then everyone requests
        resetDut();
        fixedDelay = 0;
        raiseNow   = 4'b0010;
        runCycles(6);
        fixedDelay = 2;
        raiseNow   = 4'b1111;
        resetDut();
        runCycles(40);

        // Randomised traffic with spurious engine dones and occasional resets
        fixedDelay  = -1;
        randomRaise = 1;
        spurious    = 1;
        for (int i = 0; i < 1500; i++) begin
            rstNow = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        rstNow      = 0;
        randomRaise = 0;
        spurious    = 0;
        fixedDelay  = 3;
        runCycles(200);

        @(negedge clock);
        #1;
        monOn = 0;
        checkVal("issue queue drained", 32'(issueQ.size()), 32'd0);
        checkVal("done queue drained", 32'(doneQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
